// File: rtl/pri_enc_queue_pkg.sv
// Shared constants and helpers for the pending-event priority encoder.
// Sizes, one-hot to binary conversion and population count.
package pri_enc_queue_pkg;

  localparam int N     = 4;
  localparam int W     = 2;
  localparam int CNT_W = 8;
  localparam int PW    = W + 1;

  function automatic logic [W-1:0] onehot2bin(
    input logic [N-1:0] oh
  );
    logic [W-1:0] b;
    b = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) b = b | W'(i);
    end
    return b;
  endfunction

  function automatic logic [PW-1:0] popcount(
    input logic [N-1:0] v
  );
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + PW'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/pri_enc_queue_sel.sv
// Combinational selector: highest set bit, or first set bit
// scanning upward from ptr+1 with wrap when rr is high.
module pri_sel
  import pri_enc_queue_pkg::*;
(
  input  logic [N-1:0] vec,
  input  logic [W-1:0] ptr,
  input  logic         rr,
  output logic         any,
  output logic [W-1:0] idx
);

  logic [N-1:0] grant;
  logic         found;
  logic [W-1:0] j;

  always_comb begin
    grant = '0;
    found = 1'b0;
    j     = '0;
    if (rr) begin
      // N is a power of two, so W-bit addition wraps naturally
      for (int k = 1; k <= N; k++) begin
        j = ptr + W'(k);
        if (!found && vec[j]) begin
          grant[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (!found && vec[i]) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

  assign any = |vec;
  assign idx = onehot2bin(grant);

endmodule

// File: rtl/pri_enc_queue.sv
// Captures request pulses into a pending set and issues one binary
// index per transfer on a valid/ready slot; counts merged events.
module pri_enc_queue
  import pri_enc_queue_pkg::*;
#(
  parameter int RR = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_code,
  output logic [N-1:0]     pend,
  output logic [CNT_W-1:0] lost_cnt
);

  localparam int CW1 = CNT_W + 1;

  logic [N-1:0]     pend_q, pend_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_code_q, out_code_d;
  logic [W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] lost_cnt_q, lost_cnt_d;

  logic             sel_any;
  logic [W-1:0]     sel_idx;
  logic             slot_free;
  logic             do_issue;
  logic [N-1:0]     issue;
  logic [N-1:0]     lost;
  logic [CNT_W:0]   lost_sum;

  pri_sel u_sel (
    .vec (pend_q),
    .ptr (rr_ptr_q),
    .rr  (RR != 0),
    .any (sel_any),
    .idx (sel_idx)
  );

  always_comb begin
    slot_free   = ~out_valid_q | out_ready;
    do_issue    = slot_free & sel_any;
    issue       = do_issue ? (N'(1) << sel_idx) : '0;
    // set wins over clear: a re-request of the issued index re-queues
    pend_d      = (pend_q & ~issue) | req;
    lost        = req & pend_q & ~issue;
    lost_sum    = {1'b0, lost_cnt_q} + CW1'(popcount(lost));
    lost_cnt_d  = lost_sum[CNT_W] ? '1 : lost_sum[CNT_W-1:0];
    out_valid_d = slot_free ? sel_any : out_valid_q;
    out_code_d  = do_issue ? sel_idx : out_code_q;
    rr_ptr_d    = do_issue ? sel_idx : rr_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      rr_ptr_q    <= W'(N - 1);
      lost_cnt_q  <= '0;
    end else begin
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      rr_ptr_q    <= rr_ptr_d;
      lost_cnt_q  <= lost_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_code  = out_code_q;
  assign pend      = pend_q;
  assign lost_cnt  = lost_cnt_q;

endmodule
